countdown_display: RTL and testbench

- Display-side consumer of the countdown timer's 6-bit `countdown` output.
- Converts the live binary value (0–63) to two decimal digits using a sequential repeated-subtract converter.
- Drives a 4-digit, time-multiplexed, active-low seven-segment display.
- Blinks the readout when the timer reaches zero. Sits between the countdown timer and the board display pins, on the fast system clock.

---
 rtl/display_pkg.sv | 56 +++++
 rtl/bin6_to_bcd_seq.sv | 83 ++++++++
 rtl/countdown_display.sv | 114 +++++++++++
 tb/tb_countdown_display.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the countdown seven-segment display.
package display_pkg;

    localparam int unsigned VALUE_W    = 6;
    localparam int unsigned TENS_W     = 3;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned AN_W       = 4;
    localparam int unsigned SCAN_IDX_W = 2;

    // Segment pattern, active-low, bit order gfedcba.
    typedef logic [SEG_W-1:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b1000000;
    localparam seg7_t SEG_1     = 7'b1111001;
    localparam seg7_t SEG_2     = 7'b0100100;
    localparam seg7_t SEG_3     = 7'b0110000;
    localparam seg7_t SEG_4     = 7'b0011001;
    localparam seg7_t SEG_5     = 7'b0010010;
    localparam seg7_t SEG_6     = 7'b0000010;
    localparam seg7_t SEG_7     = 7'b1111000;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0010000;
    localparam seg7_t SEG_BLANK = 7'b1111111;

    // Active-low digit enables: bit 0 = ones, bit 1 = tens.
    localparam logic [AN_W-1:0] AN_ONES = 4'b1110;
    localparam logic [AN_W-1:0] AN_TENS = 4'b1101;
    localparam logic [AN_W-1:0] AN_OFF  = 4'b1111;

    // Conversion FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    // Map a decimal digit to its segment pattern; out-of-range digits go dark.
    function automatic seg7_t digit_to_seg7(input logic [DIGIT_W-1:0] digit);
        seg7_t seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin6_to_bcd_seq.sv
// Sequential 6-bit binary to two-digit decimal converter (repeated subtract by 10).
// A new value is captured only in IDLE; the tens/ones pair updates atomically
// at the end of a conversion so partial results are never visible.
module bin6_to_bcd_seq
    import display_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic [TENS_W-1:0]  tens,
    output logic [DIGIT_W-1:0] ones
);

    localparam logic [VALUE_W-1:0] TEN = VALUE_W'(10);

    conv_state_t        state,      state_nxt;
    logic [VALUE_W-1:0] last_value, last_value_nxt;
    logic [VALUE_W-1:0] rem,        rem_nxt;
    logic [TENS_W-1:0]  tens_acc,   tens_acc_nxt;
    logic               busy_nxt;
    logic [TENS_W-1:0]  tens_nxt;
    logic [DIGIT_W-1:0] ones_nxt;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_value <= '0;
            rem        <= '0;
            tens_acc   <= '0;
            busy       <= 1'b0;
            tens       <= '0;
            ones       <= '0;
        end else begin
            state      <= state_nxt;
            last_value <= last_value_nxt;
            rem        <= rem_nxt;
            tens_acc   <= tens_acc_nxt;
            busy       <= busy_nxt;
            tens       <= tens_nxt;
            ones       <= ones_nxt;
        end
    end

    // Next-state: capture on change in IDLE, subtract tens in CONV, publish when done.
    always_comb begin
        state_nxt      = state;
        last_value_nxt = last_value;
        rem_nxt        = rem;
        tens_acc_nxt   = tens_acc;
        busy_nxt       = busy;
        tens_nxt       = tens;
        ones_nxt       = ones;

        case (state)
            ST_IDLE: begin
                if (value != last_value) begin
                    rem_nxt        = value;
                    last_value_nxt = value;
                    tens_acc_nxt   = '0;
                    busy_nxt       = 1'b1;
                    state_nxt      = ST_CONV;
                end
            end
            ST_CONV: begin
                if (rem >= TEN) begin
                    rem_nxt      = rem - TEN;
                    tens_acc_nxt = tens_acc + TENS_W'(1);
                end else begin
                    tens_nxt  = tens_acc;
                    ones_nxt  = rem[DIGIT_W-1:0];
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/countdown_display.sv
// Countdown display: converts the timer value to decimal and drives a
// 4-digit time-multiplexed active-low seven-segment display, blinking at zero.
module countdown_display
    import display_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned BLINK_HZ   = 2,
    parameter bit          LEAD_BLANK = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] countdown,
    output logic [SEG_W-1:0]   segments,
    output logic [AN_W-1:0]    anodes,
    output logic               busy
);

    localparam int unsigned SCAN_DIV  = CLK_HZ / (SCAN_HZ * 4);
    localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [TENS_W-1:0]     tens;
    logic [DIGIT_W-1:0]    ones;
    logic [SCAN_W-1:0]     scan_cnt;
    logic [BLINK_W-1:0]    blink_cnt;
    logic [SCAN_IDX_W-1:0] scan_idx;
    logic                  blink_visible;
    logic                  scan_tick_c;
    logic                  blink_tick_c;
    logic                  display_zero_c;
    seg7_t                 seg_nxt_c;
    logic [AN_W-1:0]       an_nxt_c;

    bin6_to_bcd_seq u_conv (
        .clock (clock),
        .reset (reset),
        .value (countdown),
        .busy  (busy),
        .tens  (tens),
        .ones  (ones)
    );

    assign scan_tick_c    = (scan_cnt == SCAN_LAST);
    assign blink_tick_c   = (blink_cnt == BLINK_LAST);
    assign display_zero_c = (tens == '0) && (ones == '0);

    // Scan divider and digit index.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_tick_c) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + SCAN_IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Free-running blink phase divider; phase starts visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt     <= '0;
            blink_visible <= 1'b1;
        end else if (blink_tick_c) begin
            blink_cnt     <= '0;
            blink_visible <= ~blink_visible;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Digit mux: pick the segment pattern and anode for the current scan slot.
    always_comb begin
        seg_nxt_c = SEG_BLANK;
        an_nxt_c  = AN_OFF;
        case (scan_idx)
            2'd0: begin
                an_nxt_c  = AN_ONES;
                seg_nxt_c = digit_to_seg7(ones);
            end
            2'd1: begin
                if (!(LEAD_BLANK && (tens == '0))) begin
                    an_nxt_c  = AN_TENS;
                    seg_nxt_c = digit_to_seg7(DIGIT_W'(tens));
                end
            end
            default: begin
                an_nxt_c  = AN_OFF;
                seg_nxt_c = SEG_BLANK;
            end
        endcase
        if (display_zero_c && !blink_visible) begin
            an_nxt_c = AN_OFF;
        end
    end

    // Segments and anodes registered together so they switch on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            segments <= SEG_BLANK;
            anodes   <= AN_OFF;
        end else begin
            segments <= seg_nxt_c;
            anodes   <= an_nxt_c;
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// Bench for countdown_display: a cycle-level reference model feeds a scoreboard
// checked every cycle, plus table vectors and hand sequences for corner cases.
module tb_countdown_display;

    localparam int unsigned CLK_HZ   = 400;
    localparam int unsigned SCAN_HZ  = 10;
    localparam int unsigned BLINK_HZ = 20;
    localparam int unsigned SLOT     = CLK_HZ / (SCAN_HZ * 4);
    localparam int unsigned HALF     = CLK_HZ / (2 * BLINK_HZ);

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] countdown;
    logic [6:0] segments;
    logic [3:0] anodes;
    logic       busy;

    always #5 clk = ~clk;

    countdown_display #(
        .CLK_HZ     (CLK_HZ),
        .SCAN_HZ    (SCAN_HZ),
        .BLINK_HZ   (BLINK_HZ),
        .LEAD_BLANK (1'b1)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .countdown (countdown),
        .segments  (segments),
        .anodes    (anodes),
        .busy      (busy)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic [5:0] val;
        int         busy_n;
        logic       tens_lit;
        logic [6:0] tens_seg;
        logic [6:0] ones_seg;
    } vec_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: edges since reset, shown value, pending conversion.
    int   m_cnt  = 0;
    int   m_disp = 0;
    int   m_last = 0;
    int   m_pend = 0;
    int   m_left = 0;
    logic m_busy = 1'b0;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // One clock: model predicts this edge's outputs at posedge, compared at negedge.
    task automatic tick();
        exp_t e;
        exp_t g;
        int   idx;
        bit   vis;
        @(posedge clk);
        if (reset) begin
            e      = '{seg: 7'h7f, an: 4'hf, busy: 1'b0};
            m_cnt  = 0;
            m_disp = 0;
            m_last = 0;
            m_left = 0;
            m_busy = 1'b0;
        end else begin
            idx   = (m_cnt / SLOT) % 4;
            vis   = ((m_cnt / HALF) % 2) == 0;
            e.seg = 7'h7f;
            e.an  = 4'hf;
            if (idx == 0) begin
                e.an  = 4'b1110;
                e.seg = enc(m_disp % 10);
            end else if (idx == 1 && m_disp >= 10) begin
                e.an  = 4'b1101;
                e.seg = enc(m_disp / 10);
            end
            if (m_disp == 0 && !vis) e.an = 4'hf;
            if (m_left == 0) begin
                if (int'(countdown) != m_last) begin
                    m_last = int'(countdown);
                    m_pend = int'(countdown);
                    m_left = int'(countdown) / 10 + 1;
                    m_busy = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_disp = m_pend;
                    m_busy = 1'b0;
                end
            end
            e.busy = m_busy;
            m_cnt++;
        end
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        check("cyc_seg", int'(segments), int'(g.seg));
        check("cyc_an", int'(anodes), int'(g.an));
        check("cyc_busy", int'(busy), int'(g.busy));
    endtask

    // Watch a full scan period and record what the ones and tens slots showed.
    task automatic scan_digits(output logic [6:0] t_seg, output logic [6:0] o_seg,
                               output bit t_seen, output bit o_seen);
        t_seg  = 7'h7f;
        o_seg  = 7'h7f;
        t_seen = 1'b0;
        o_seen = 1'b0;
        repeat (4 * SLOT + 5) begin
            tick();
            if (anodes == 4'b1110) begin
                o_seen = 1'b1;
                o_seg  = segments;
            end
            if (anodes == 4'b1101) begin
                t_seen = 1'b1;
                t_seg  = segments;
            end
        end
    endtask

    initial begin
        vec_t       vecs[6];
        logic [6:0] t_seg;
        logic [6:0] o_seg;
        bit         t_seen;
        bit         o_seen;
        int         n;
        int         tens_low;
        int         busy_hi;
        int         ones_on;
        int         bad;

        vecs[0] = '{6'd42, 5, 1'b1, 7'b0011001, 7'b0100100};
        vecs[1] = '{6'd63, 7, 1'b1, 7'b0000010, 7'b0110000};
        vecs[2] = '{6'd7,  1, 1'b0, 7'b1111111, 7'b1111000};
        vecs[3] = '{6'd10, 2, 1'b1, 7'b1111001, 7'b1000000};
        vecs[4] = '{6'd9,  1, 1'b0, 7'b1111111, 7'b0010000};
        vecs[5] = '{6'd0,  1, 1'b0, 7'b1111111, 7'b1000000};

        // Reset state, then release with countdown held at zero.
        reset     = 1'b1;
        countdown = 6'd0;
        repeat (3) tick();
        check("rst_seg", int'(segments), 'h7f);
        check("rst_an", int'(anodes), 'hf);
        check("rst_busy", int'(busy), 0);
        reset    = 1'b0;
        tens_low = 0;
        busy_hi  = 0;
        ones_on  = 0;
        repeat (4 * SLOT) begin
            tick();
            if (!anodes[1]) tens_low++;
            if (busy) busy_hi++;
            if (anodes == 4'b1110 && segments == 7'b1000000) ones_on++;
        end
        check("zero_tens_dark", tens_low, 0);
        check("zero_busy_idle", busy_hi, 0);
        check("zero_ones_lit", ones_on, int'(SLOT));

        // Table vectors: busy length and what each digit slot shows afterwards.
        for (int i = 0; i < 6; i++) begin
            countdown = vecs[i].val;
            n = 0;
            tick();
            while (busy && n < 20) begin
                n++;
                tick();
            end
            check("busy_len", n, vecs[i].busy_n);
            scan_digits(t_seg, o_seg, t_seen, o_seen);
            check("ones_lit", int'(o_seen), 1);
            check("ones_seg", int'(o_seg), int'(vecs[i].ones_seg));
            check("tens_lit", int'(t_seen), int'(vecs[i].tens_lit));
            if (vecs[i].tens_lit) check("tens_seg", int'(t_seg), int'(vecs[i].tens_seg));
        end

        // 0 -> 42, then 36 arrives two cycles into the conversion.
        countdown = 6'd42;
        repeat (2) tick();
        countdown = 6'd36;
        bad = 0;
        repeat (30) begin
            tick();
            if (anodes == 4'b1110 && segments != enc(0) && segments != enc(2) && segments != enc(6)) bad++;
            if (anodes == 4'b1101 && segments != enc(4) && segments != enc(3)) bad++;
        end
        check("no_partial", bad, 0);
        scan_digits(t_seg, o_seg, t_seen, o_seen);
        check("final_tens", int'(t_seg), int'(enc(3)));
        check("final_ones", int'(o_seg), int'(enc(6)));

        // Reset in the middle of a 36 -> 63 conversion and mid-scan.
        countdown = 6'd63;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midrst_an", int'(anodes), 'hf);
        check("midrst_seg", int'(segments), 'h7f);
        check("midrst_busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        tick();
        check("reconv_busy", int'(busy), 1);
        repeat (10) tick();
        scan_digits(t_seg, o_seg, t_seen, o_seen);
        check("reconv_tens", int'(t_seg), int'(enc(6)));
        check("reconv_ones", int'(o_seg), int'(enc(3)));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
